// File: rtl/emux_rx_multi.sv
// emux_rx_multi: multi-channel UDP-port receive demultiplexer.
// Watches a 12-bit upstream byte bus, matches the two-byte destination
// port against a per-channel table, steers the payload strobe to the
// selected channel and counts good frames per channel plus unmatched
// headers. The upstream bus is re-registered on out_c so several
// demux blocks can be daisy-chained.
module emux_rx_multi #(
  parameter int                    N_PORT    = 4,
  parameter logic [16*N_PORT-1:0]  PORT_LIST = {16'd803, 16'd802, 16'd801, 16'd800},
  parameter int                    CW        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            in_c,
  output logic [11:0]            out_c,
  input  logic [N_PORT-1:0]      en,
  input  logic                   count_clr,
  output logic [N_PORT-1:0]      ready,
  output logic [N_PORT-1:0]      strobe,
  output logic [N_PORT-1:0]      crc,
  output logic [7:0]             data,
  output logic [N_PORT-1:0]      active,
  output logic [N_PORT*CW-1:0]   frame_count,
  output logic [CW-1:0]          miss_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEL  = 1'b1
  } state_e;

  // Saturating increment shared by every counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == {CW{1'b1}}) begin
      r = v;
    end else begin
      r = v + CW'(1);
    end
    return r;
  endfunction

  // Upstream bus fields.
  logic        in_crc_s;
  logic        in_s_s;
  logic        in_p_s;
  logic [7:0]  in_d_s;

  assign in_crc_s = in_c[11];
  assign in_s_s   = in_c[9];
  assign in_p_s   = in_c[8];
  assign in_d_s   = in_c[7:0];

  // State
  state_e                       state_q,  state_d;
  logic [N_PORT-1:0]            active_q, active_d;
  logic [N_PORT-1:0]            hi_match_q;
  logic [N_PORT-1:0]            crc_q;
  logic [11:0]                  out_c_q;
  logic [N_PORT-1:0][CW-1:0]    fcnt_q,   fcnt_d;
  logic [CW-1:0]                miss_q,   miss_d;

  // Combinational helpers
  logic [N_PORT-1:0]            ready_s;
  logic [N_PORT-1:0]            first_s;
  logic                         any_ready_s;

  // Port match: low byte compared now, high byte remembered from the previous cycle.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < N_PORT; i++) begin
      ready_s[i] = in_p_s & (in_d_s == PORT_LIST[16*i +: 8]) & hi_match_q[i] & en[i];
    end
  end

  assign any_ready_s = |ready_s;

  // Lowest-index priority select so duplicate ports resolve to the lower channel.
  always_comb begin
    first_s = '0;
    for (int i = N_PORT - 1; i >= 0; i--) begin
      if (ready_s[i]) begin
        first_s    = '0;
        first_s[i] = 1'b1;
      end else begin
        first_s = first_s;
      end
    end
  end

  // High-byte match register, refreshed on every byte regardless of markers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_match_q <= '0;
    end else begin
      for (int i = 0; i < N_PORT; i++) begin
        hi_match_q[i] <= (in_d_s == PORT_LIST[16*i+8 +: 8]);
      end
    end
  end

  // Selection FSM next state: a p-marked byte always re-evaluates, a crc in SEL closes the frame.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (in_p_s) begin
          active_d = first_s;
          state_d  = any_ready_s ? SEL : IDLE;
        end else begin
          active_d = active_q;
          state_d  = IDLE;
        end
      end
      SEL: begin
        if (in_p_s) begin
          active_d = first_s;
          state_d  = any_ready_s ? SEL : IDLE;
        end else if (in_crc_s) begin
          active_d = '0;
          state_d  = IDLE;
        end else begin
          active_d = active_q;
          state_d  = SEL;
        end
      end
      default: begin
        active_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // Selection FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  // Counter next state: clear wins over any increment in the same cycle.
  always_comb begin
    fcnt_d = fcnt_q;
    miss_d = miss_q;
    if (count_clr) begin
      fcnt_d = '0;
      miss_d = '0;
    end else begin
      for (int i = 0; i < N_PORT; i++) begin
        if (in_crc_s && active_q[i] && (state_q == SEL)) begin
          fcnt_d[i] = sat_inc(fcnt_q[i]);
        end else begin
          fcnt_d[i] = fcnt_q[i];
        end
      end
      if (in_p_s && !any_ready_s) begin
        miss_d = sat_inc(miss_q);
      end else begin
        miss_d = miss_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      miss_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      miss_q <= miss_d;
    end
  end

  // Daisy-chain bus copy and per-channel frame-end pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_c_q <= 12'h000;
      crc_q   <= '0;
    end else begin
      out_c_q <= in_c;
      crc_q   <= {N_PORT{in_crc_s}} & active_q;
    end
  end

  assign out_c       = out_c_q;
  assign crc         = crc_q;
  assign ready       = ready_s;
  assign strobe      = {N_PORT{in_s_s}} & active_q;
  assign data        = in_d_s;
  assign active      = active_q;
  assign frame_count = fcnt_q;
  assign miss_count  = miss_q;

endmodule

// File: tb/tb_emux_rx_multi.sv
// Directed bench for emux_rx_multi: default table, a table with a
// duplicated port, and a 4-bit counter variant, all fed the same bus.
module tb_emux_rx_multi;

  logic        clk;
  logic        rst_n;
  logic [11:0] in_c;
  logic [3:0]  en;
  logic        count_clr;

  logic [11:0] u0_out_c, u1_out_c, u2_out_c;
  logic [3:0]  u0_ready, u1_ready, u2_ready;
  logic [3:0]  u0_strobe, u1_strobe, u2_strobe;
  logic [3:0]  u0_crc, u1_crc, u2_crc;
  logic [7:0]  u0_data, u1_data, u2_data;
  logic [3:0]  u0_active, u1_active, u2_active;
  logic [63:0] u0_fc, u1_fc;
  logic [15:0] u2_fc;
  logic [15:0] u0_miss, u1_miss;
  logic [3:0]  u2_miss;

  int n_assert;
  int n_fail;

  emux_rx_multi u0 (
    .clk(clk), .rst_n(rst_n), .in_c(in_c), .out_c(u0_out_c), .en(en),
    .count_clr(count_clr), .ready(u0_ready), .strobe(u0_strobe), .crc(u0_crc),
    .data(u0_data), .active(u0_active), .frame_count(u0_fc), .miss_count(u0_miss)
  );

  emux_rx_multi #(.PORT_LIST({16'd800, 16'd802, 16'd801, 16'd800})) u1 (
    .clk(clk), .rst_n(rst_n), .in_c(in_c), .out_c(u1_out_c), .en(en),
    .count_clr(count_clr), .ready(u1_ready), .strobe(u1_strobe), .crc(u1_crc),
    .data(u1_data), .active(u1_active), .frame_count(u1_fc), .miss_count(u1_miss)
  );

  emux_rx_multi #(.CW(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_c(in_c), .out_c(u2_out_c), .en(en),
    .count_clr(count_clr), .ready(u2_ready), .strobe(u2_strobe), .crc(u2_crc),
    .data(u2_data), .active(u2_active), .frame_count(u2_fc), .miss_count(u2_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] hb(input logic [7:0] d);
    return {4'b0000, d};
  endfunction
  function automatic logic [11:0] pb(input logic [7:0] d);
    return {4'b0001, d};
  endfunction
  function automatic logic [11:0] sb(input logic [7:0] d);
    return {4'b0010, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [11:0] v);
    in_c = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete good frame on port 800.
  task automatic frame800();
    drive(hb(8'h03)); tick();
    drive(pb(8'h20)); tick();
    drive(sb(8'h11)); tick();
    drive(12'h800);   tick();
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_c      = 12'h000;
    en        = 4'hF;
    count_clr = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_out_c",  {52'd0, u0_out_c}, 64'h0);
    chk("rst_active", {60'd0, u0_active}, 64'h0);
    chk("rst_crc",    {60'd0, u0_crc}, 64'h0);
    chk("rst_fc",     u0_fc, 64'h0);
    chk("rst_miss",   {48'd0, u0_miss}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Port 801 frame
    drive(hb(8'h03)); tick();
    drive(pb(8'h21));
    chk("p801_ready",    {60'd0, u0_ready}, 64'h2);
    chk("p801_ready_u1", {60'd0, u1_ready}, 64'h2);
    tick();
    chk("p801_active", {60'd0, u0_active}, 64'h2);
    drive(sb(8'hAA));
    chk("p801_strobe", {60'd0, u0_strobe}, 64'h2);
    chk("p801_data",   {56'd0, u0_data}, 64'hAA);
    tick();
    chk("out_c_delay", {52'd0, u0_out_c}, 64'h2AA);
    drive(12'h800);
    chk("crc_not_yet", {60'd0, u0_crc}, 64'h0);
    tick();
    chk("crc_pulse",   {60'd0, u0_crc}, 64'h2);
    chk("fc1_one",     {48'd0, u0_fc[31:16]}, 64'h1);
    chk("idle_after_crc", {60'd0, u0_active}, 64'h0);
    drive(12'h000); tick();
    chk("crc_gone", {60'd0, u0_crc}, 64'h0);

    // Port 9999 (0x270F): unmatched header
    drive(hb(8'h27)); tick();
    drive(pb(8'h0F));
    chk("p9999_ready", {60'd0, u0_ready}, 64'h0);
    tick();
    chk("p9999_active", {60'd0, u0_active}, 64'h0);
    chk("p9999_miss",   {48'd0, u0_miss}, 64'h1);
    drive(sb(8'h55));
    chk("p9999_strobe", {60'd0, u0_strobe}, 64'h0);
    tick();

    // Low byte 0x21 after a wrong high byte does not match
    drive(hb(8'h04)); tick();
    drive(pb(8'h21));
    chk("badhi_ready", {60'd0, u0_ready}, 64'h0);
    tick();
    chk("badhi_miss", {48'd0, u0_miss}, 64'h2);

    // Channel 2 disabled at header time
    en = 4'b1011;
    drive(hb(8'h03)); tick();
    drive(pb(8'h22));
    chk("en2_ready", {60'd0, u0_ready}, 64'h0);
    tick();
    chk("en2_active", {60'd0, u0_active}, 64'h0);
    chk("en2_miss",   {48'd0, u0_miss}, 64'h3);
    en = 4'hF;

    // en[1] dropped mid-frame: frame still completes
    drive(hb(8'h03)); tick();
    drive(pb(8'h21)); tick();
    drive(sb(8'h01));
    chk("en1_strobe_a", {60'd0, u0_strobe}, 64'h2);
    tick();
    en = 4'b1101;
    drive(sb(8'h02));
    chk("en1_strobe_b", {60'd0, u0_strobe}, 64'h2);
    tick();
    drive(12'h800); tick();
    chk("en1_fc1_two", {48'd0, u0_fc[31:16]}, 64'h2);
    en = 4'hF;

    // Duplicate port 800 on channels 0 and 3
    drive(hb(8'h03)); tick();
    drive(pb(8'h20));
    chk("dup_ready", {60'd0, u1_ready}, 64'h9);
    tick();
    chk("dup_active", {60'd0, u1_active}, 64'h1);
    drive(sb(8'h22));
    chk("dup_strobe", {60'd0, u1_strobe}, 64'h1);
    tick();
    drive(12'h800); tick();
    chk("dup_crc", {60'd0, u1_crc}, 64'h1);
    chk("dup_fc0", {48'd0, u1_fc[15:0]}, 64'h1);
    chk("dup_fc3", {48'd0, u1_fc[63:48]}, 64'h0);

    // 15 more frames on port 800: 16 in total
    for (int k = 0; k < 15; k++) begin
      frame800();
    end
    chk("sat_cw4_fc0",  {60'd0, u2_fc[3:0]}, 64'hF);
    chk("cw16_fc0_16",  {48'd0, u0_fc[15:0]}, 64'h10);

    // Clear coincident with a crc pulse
    drive(hb(8'h03)); tick();
    drive(pb(8'h20)); tick();
    drive(sb(8'h33)); tick();
    drive(12'h800);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    chk("clr_cw4_fc0", {60'd0, u2_fc[3:0]}, 64'h0);
    chk("clr_fc0",     {48'd0, u0_fc[15:0]}, 64'h0);
    chk("clr_fc1",     {48'd0, u0_fc[31:16]}, 64'h0);
    chk("clr_miss",    {48'd0, u0_miss}, 64'h0);

    // Reset pulsed mid-payload
    drive(hb(8'h03)); tick();
    drive(pb(8'h21)); tick();
    drive(sb(8'h66)); tick();
    drive(sb(8'h77));
    rst_n = 1'b0;
    #1;
    chk("mrst_out_c",  {52'd0, u0_out_c}, 64'h0);
    chk("mrst_active", {60'd0, u0_active}, 64'h0);
    chk("mrst_strobe", {60'd0, u0_strobe}, 64'h0);
    tick();
    rst_n = 1'b1;
    drive(sb(8'h78));
    chk("post_rst_strobe", {60'd0, u0_strobe}, 64'h0);
    tick();
    drive(hb(8'h03)); tick();
    drive(pb(8'h21)); tick();
    chk("resume_active", {60'd0, u0_active}, 64'h2);
    drive(sb(8'h79));
    chk("resume_strobe", {60'd0, u0_strobe}, 64'h2);
    tick();

    // Re-evaluation while selected: header 803 switches to channel 3
    drive(hb(8'h03)); tick();
    drive(pb(8'h23)); tick();
    chk("reeval_active", {60'd0, u0_active}, 64'h8);
    drive(12'h000); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/emux_rx_multi.md
EMUX_RX_MULTI -- requirements
Module: emux_rx_multi

Interface
REQ-001 The block SHALL have parameter N_PORT, default 4, giving the number of client channels (legal range 1..8).
REQ-002 The block SHALL have parameter PORT_LIST, default {16'd803,16'd802,16'd801,16'd800}, holding the UDP port of channel i in bits [16i+15:16i].
REQ-003 The block SHALL have parameter CW, default 16, giving the width of every counter.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_c  input  12  upstream bus: [11]=crc (frame-end, CRC good), [10] unused, [9]=s (payload strobe), [8]=p (port-low-byte marker), [7:0]=d (data byte).
REQ-008 out_c  output  12  in_c delayed one clk, for daisy-chaining the next demux.
REQ-009 en  input  N_PORT  per-channel enable.
REQ-010 count_clr  input  1  synchronous clear of all counters.
REQ-011 ready  output  N_PORT  per-channel port-match pulse, combinational.
REQ-012 strobe  output  N_PORT  per-channel payload strobe.
REQ-013 crc  output  N_PORT  per-channel frame-end pulse, registered.
REQ-014 data  output  8  in_c[7:0], shared by all channels.
REQ-015 active  output  N_PORT  one-hot (or zero) current selection.
REQ-016 frame_count  output  N_PORT*CW  good frames per channel; channel i in bits [CW*i+CW-1:CW*i].
REQ-017 miss_count  output  CW  p-marked headers that selected no channel.

Function
REQ-018 out_c SHALL equal in_c from the previous clk cycle (latency 1).
REQ-019 hi_match[i] SHALL be registered every cycle as (in_c[7:0] == PORT_LIST[16i+15:16i+8]).
REQ-020 ready[i] SHALL equal in_p & (in_c[7:0] == PORT_LIST[16i+7:16i]) & hi_match[i] & en[i].
REQ-021 The state machine SHALL have two states: IDLE (active==0) and SEL (active one-hot).
REQ-022 When in_p is high, the block SHALL load active with the lowest-index set bit of ready (entering SEL) or with zero if ready==0 (entering IDLE), in both IDLE and SEL; this is a re-evaluation.
REQ-023 When in_p is high and ready==0, miss_count SHALL increment.
REQ-024 When in_p is low, active SHALL hold.
REQ-025 Duplicate ports in PORT_LIST SHALL resolve to the lowest index; higher duplicates never assert strobe.
REQ-026 strobe[i] SHALL equal in_s & active[i] (combinational, same cycle as data).
REQ-027 crc[i] SHALL be registered as in_crc & active[i] (one cycle after in_crc).
REQ-028 On in_crc high in SEL, frame_count of the selected channel SHALL increment and the state SHALL go to IDLE on the same edge.
REQ-029 en SHALL be sampled only via ready at in_p; deasserting en mid-frame SHALL NOT stop the current frame.
REQ-030 All counters SHALL saturate at 2^CW-1.
REQ-031 count_clr SHALL zero all counters next edge, overriding a simultaneous increment.

Reset
REQ-032 On rst_n low, asynchronously: out_c=0, hi_match=0, active=0, crc=0, all counters 0; strobe consequently 0.
REQ-033 After a mid-frame reset, strobes SHALL stay low until a new matching in_p header.
REQ-034 After rst_n deassertion, the block SHALL be in IDLE.

Verification
REQ-035 Bytes 0x03,0x21 (p on 0x21) with ports 800/801/802/803, en=4'hF -> ready=4'b0010 on the 0x21 cycle; s-bytes give strobe=4'b0010; crc pulse gives crc[1] one cycle later; frame_count[1]=1.
REQ-036 Header for port 9999 -> ready=0, active=0, no strobes, miss_count=1.
REQ-037 en[2]=0 with header 802 -> no selection, miss_count increments; toggling en[1] low during a port-801 payload -> strobes continue, frame_count[1] increments.
REQ-038 PORT_LIST with channels 0 and 3 both 800 -> only channel 0 strobes and counts.
REQ-039 CW=4, 16 good frames on channel 0 -> count stays 15; count_clr coincident with a crc pulse -> count 0.
REQ-040 rst_n pulsed low mid-payload -> out_c=0, active=0 immediately; remaining s-bytes give no strobe; next valid header resumes normally.
